// File: rtl/gps_correlator.sv
// gps_correlator: single-channel GPS L1 C/A carrier wipeoff, despreading and E/P/L epoch integration
module gps_correlator #(
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             dv_in,
  input  logic [7:0]       real_in,
  input  logic [7:0]       imag_in,
  input  logic [31:0]      code_freq,
  input  logic [31:0]      dop_freq,
  input  logic [5:0]       ca_sel,
  output logic             dv_out,
  output logic [ACC_W-1:0] e_i,
  output logic [ACC_W-1:0] e_q,
  output logic [ACC_W-1:0] p_i,
  output logic [ACC_W-1:0] p_q,
  output logic [ACC_W-1:0] l_i,
  output logic [ACC_W-1:0] l_q,
  output logic [15:0]      epoch_cnt
);
  localparam logic signed [ACC_W:0] MAX = (ACC_W+1)'(2**(ACC_W-1) - 1);
  // G2 tap pairs for SV1..SV36, one nibble per tap position
  localparam logic [7:0] TAPS [36] = '{
    8'h26, 8'h37, 8'h48, 8'h59, 8'h19, 8'h2a, 8'h18, 8'h29, 8'h3a, 8'h23,
    8'h34, 8'h56, 8'h67, 8'h78, 8'h89, 8'h9a, 8'h14, 8'h25, 8'h36, 8'h47,
    8'h58, 8'h69, 8'h13, 8'h46, 8'h57, 8'h68, 8'h79, 8'h8a, 8'h16, 8'h27,
    8'h38, 8'h49, 8'h5a, 8'h4a, 8'h17, 8'h28};
  logic [31:0] code_phase, carr_phase;
  logic [32:0] code_sum;
  logic [10:1] g1, g2, g1n, g2n, mask, tap_mask;
  logic [7:0] tap;
  logic [9:0] chip_idx;
  logic e_c, p_c, l_c, half, full, last, v1, last1;
  logic [1:0] q;
  logic signed [8:0] si, sq, wi, wq;
  logic signed [8:0] prod [6];
  logic signed [8:0] prod_r [6];
  logic signed [ACC_W:0] sum [6];
  logic signed [ACC_W-1:0] nxt [6];
  logic signed [ACC_W-1:0] acc [6];
  logic signed [ACC_W-1:0] dump [6];
  always_comb begin
    si = {real_in[7], real_in};
    sq = {imag_in[7], imag_in};
    q = carr_phase[31:30];
    wi = q == 2'd0 ? si : q == 2'd1 ? sq : q == 2'd2 ? -si : -sq;
    wq = q == 2'd0 ? sq : q == 2'd1 ? -si : q == 2'd2 ? -sq : si;
    prod[0] = e_c ? -wi : wi;
    prod[1] = e_c ? -wq : wq;
    prod[2] = p_c ? -wi : wi;
    prod[3] = p_c ? -wq : wq;
    prod[4] = l_c ? -wi : wi;
    prod[5] = l_c ? -wq : wq;
    code_sum = {1'b0, code_phase} + {1'b0, code_freq};
    full = code_sum[32];
    half = code_sum[31] ^ code_phase[31];
    last = full && chip_idx == 10'd1022;
    g1n = {g1[9:1], g1[3] ^ g1[10]};
    g2n = {g2[9:1], g2[2] ^ g2[3] ^ g2[6] ^ g2[8] ^ g2[9] ^ g2[10]};
    tap = TAPS[ca_sel < 6'd36 ? ca_sel : 6'd0];
    mask = (10'd1 << (tap[7:4] - 4'd1)) | (10'd1 << (tap[3:0] - 4'd1));
    for (int k = 0; k < 6; k++) begin
      sum[k] = (ACC_W+1)'(acc[k]) + (ACC_W+1)'(prod_r[k]);
      nxt[k] = sum[k] > MAX ? MAX[ACC_W-1:0] : sum[k] < -MAX ? ACC_W'(-MAX) : sum[k][ACC_W-1:0];
    end
  end
  always_ff @(posedge clk)
    if (reset || !enable) tap_mask <= mask;
  // all-ones G1/G2 always yield chip 1, so E/P/L restart at 1 for every SV
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      code_phase <= '0; carr_phase <= '0; chip_idx <= '0;
      g1 <= '1; g2 <= '1; {e_c, p_c, l_c} <= '1;
      v1 <= 1'b0; last1 <= 1'b0; prod_r <= '{default: '0};
    end else if (!enable) begin
      code_phase <= '0; carr_phase <= '0; chip_idx <= '0;
      g1 <= '1; g2 <= '1; {e_c, p_c, l_c} <= '1;
      v1 <= 1'b0; last1 <= 1'b0; prod_r <= '{default: '0};
    end else begin
      v1 <= dv_in;
      last1 <= dv_in && last;
      if (dv_in) begin
        prod_r <= prod;
        carr_phase <= carr_phase + dop_freq;
        code_phase <= code_sum[31:0];
        if (half) {l_c, p_c} <= {p_c, e_c};
        if (full) begin
          g1 <= g1n;
          g2 <= g2n;
          e_c <= g1n[10] ^ (^(g2n & tap_mask));
          chip_idx <= last ? '0 : chip_idx + 10'd1;
        end
      end
    end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      acc <= '{default: '0}; dump <= '{default: '0}; dv_out <= 1'b0; epoch_cnt <= '0;
    end else if (!enable) begin
      acc <= '{default: '0}; dump <= '{default: '0}; dv_out <= 1'b0; epoch_cnt <= '0;
    end else begin
      dv_out <= v1 && last1;
      if (v1 && last1) begin
        dump <= nxt;
        acc <= '{default: '0};
        epoch_cnt <= epoch_cnt + 16'd1;
      end else if (v1) acc <= nxt;
    end
  assign e_i = dump[0];
  assign e_q = dump[1];
  assign p_i = dump[2];
  assign p_q = dump[3];
  assign l_i = dump[4];
  assign l_q = dump[5];
endmodule

// File: tb/tb_gps_correlator.sv
// tb_gps_correlator: scoreboard bench for gps_correlator at ACC_W=24 and ACC_W=12 side by side
module tb_gps_correlator;
  logic clk = 0, reset = 1, enable = 0, dv_in = 0;
  logic [7:0] real_in = 0, imag_in = 0;
  logic [31:0] code_freq = 0, dop_freq = 0;
  logic [5:0] ca_sel = 0;
  logic dv_out, dv12;
  logic [23:0] e_i, e_q, p_i, p_q, l_i, l_q;
  logic [11:0] e_i12, e_q12, p_i12, p_q12, l_i12, l_q12;
  logic [15:0] epoch_cnt, cnt12;
  logic signed [23:0] g24 [6];
  logic signed [11:0] g12 [6];
  assign g24 = '{e_i, e_q, p_i, p_q, l_i, l_q};
  assign g12 = '{e_i12, e_q12, p_i12, p_q12, l_i12, l_q12};

  typedef struct packed {
    logic [5:0][31:0] v24;
    logic [5:0][31:0] v12;
    logic [31:0] cnt;
    logic [31:0] cyc;
  } exp_t;
  exp_t sb [$];
  bit code [1023];
  int tap_a = 2, tap_b = 6;
  logic [31:0] m_code, m_carr;
  int idx, m_cnt, cyc = 0, n_tests = 0, n_fail = 0;
  bit ec, pc, lc;
  int a24 [6], a12 [6];
  logic [9:0] chips = 0;
  string names [6] = '{"e_i", "e_q", "p_i", "p_q", "l_i", "l_q"};

  gps_correlator #(.ACC_W(24)) dut (
    .clk(clk), .reset(reset), .enable(enable), .dv_in(dv_in), .real_in(real_in), .imag_in(imag_in),
    .code_freq(code_freq), .dop_freq(dop_freq), .ca_sel(ca_sel), .dv_out(dv_out),
    .e_i(e_i), .e_q(e_q), .p_i(p_i), .p_q(p_q), .l_i(l_i), .l_q(l_q), .epoch_cnt(epoch_cnt));
  gps_correlator #(.ACC_W(12)) dut12 (
    .clk(clk), .reset(reset), .enable(enable), .dv_in(dv_in), .real_in(real_in), .imag_in(imag_in),
    .code_freq(code_freq), .dop_freq(dop_freq), .ca_sel(ca_sel), .dv_out(dv12),
    .e_i(e_i12), .e_q(e_q12), .p_i(p_i12), .p_q(p_q12), .l_i(l_i12), .l_q(l_q12), .epoch_cnt(cnt12));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string tag, longint got, longint exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int sat(int v, int w);
    int m = (1 << (w - 1)) - 1;
    return v > m ? m : v < -m ? -m : v;
  endfunction

  task automatic model_reset();
    bit g1 [1:10];
    bit g2 [1:10];
    bit f1, f2;
    g1 = '{default: 1};
    g2 = '{default: 1};
    for (int n = 0; n < 1023; n++) begin
      code[n] = g1[10] ^ g2[tap_a] ^ g2[tap_b];
      f1 = g1[3] ^ g1[10];
      f2 = g2[2] ^ g2[3] ^ g2[6] ^ g2[8] ^ g2[9] ^ g2[10];
      for (int j = 10; j > 1; j--) begin
        g1[j] = g1[j-1];
        g2[j] = g2[j-1];
      end
      g1[1] = f1;
      g2[1] = f2;
    end
    m_code = 0; m_carr = 0; idx = 0; m_cnt = 0;
    ec = code[0]; pc = code[0]; lc = code[0];
    a24 = '{default: 0};
    a12 = '{default: 0};
  endtask

  // one sample through the reference: wipe, despread with pre-update chips, then advance the NCOs
  task automatic model_step(int re, int im);
    int wi, wq, s;
    bit ch [3];
    logic [32:0] ns;
    bit half, ep;
    exp_t x;
    case (m_carr[31:30])
      2'd0: begin wi = re; wq = im; end
      2'd1: begin wi = im; wq = -re; end
      2'd2: begin wi = -re; wq = -im; end
      default: begin wi = -im; wq = re; end
    endcase
    ch = '{ec, pc, lc};
    for (int k = 0; k < 3; k++) begin
      s = ch[k] ? -1 : 1;
      a24[2*k] = sat(a24[2*k] + s * wi, 24);
      a24[2*k+1] = sat(a24[2*k+1] + s * wq, 24);
      a12[2*k] = sat(a12[2*k] + s * wi, 12);
      a12[2*k+1] = sat(a12[2*k+1] + s * wq, 12);
    end
    ns = {1'b0, m_code} + {1'b0, code_freq};
    half = ns[31] != m_code[31];
    ep = 0;
    m_code = ns[31:0];
    m_carr = m_carr + dop_freq;
    if (half) begin
      lc = pc;
      pc = ec;
    end
    if (ns[32]) begin
      ep = idx == 1022;
      idx = ep ? 0 : idx + 1;
      ec = code[idx];
    end
    if (ep) begin
      m_cnt = (m_cnt + 1) % 65536;
      for (int k = 0; k < 6; k++) begin
        x.v24[k] = a24[k];
        x.v12[k] = a12[k];
      end
      x.cnt = m_cnt;
      x.cyc = cyc + 2;
      sb.push_back(x);
      a24 = '{default: 0};
      a12 = '{default: 0};
    end
  endtask

  task automatic step(bit dv, int re, int im);
    dv_in = dv;
    real_in = 8'(re);
    imag_in = 8'(im);
    if (dv && enable) model_step(re, im);
    @(negedge clk);
  endtask

  task automatic chan_off(int n);
    enable = 0;
    dv_in = 0;
    repeat (n) @(negedge clk);
    model_reset();
    enable = 1;
  endtask

  always @(negedge clk)
    if (dv_out) begin
      if (sb.size() == 0) check("spurious_dv_out", 1, 0);
      else begin
        exp_t x;
        x = sb.pop_front();
        check("dv_out_cycle", cyc, x.cyc);
        check("epoch_cnt", epoch_cnt, x.cnt);
        check("dv_out12", dv12, 1);
        check("epoch_cnt12", cnt12, x.cnt);
        for (int k = 0; k < 6; k++) begin
          check(names[k], g24[k], $signed(x.v24[k]));
          check({names[k], "_12"}, g12[k], $signed(x.v12[k]));
        end
      end
    end

  initial begin
    #1_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_dv_out", dv_out, 0);
    check("rst_p_i", g24[2], 0);
    check("rst_epoch_cnt", epoch_cnt, 0);
    reset = 0;
    @(negedge clk);
    code_freq = 32'h8000_0000;
    enable = 1;
    for (int n = 0; n < 4092; n++) begin
      if (n < 20 && n % 2 == 0) chips = {chips[8:0], dut.e_c};
      step(1, 1, 0);
    end
    repeat (4) step(0, 0, 0);
    check("t1_chips", chips, 10'o1440);
    check("t1_e_i", g24[0], -2);
    check("t1_p_i", g24[2], -2);
    check("t1_p_q", g24[3], 0);
    check("t1_epoch_cnt", epoch_cnt, 2);
    ca_sel = 3; tap_a = 5; tap_b = 9;
    chan_off(1);
    for (int n = 0; n < 1000; n++) begin
      if (n == 500) ca_sel = 10;
      step(1, int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128);
    end
    ca_sel = 3;
    chan_off(3);
    for (int n = 0; n < 2046; n++) begin
      if (n == 100) ca_sel = 10;
      step(1, int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128);
    end
    repeat (4) step(0, 0, 0);
    check("t5_epoch_cnt", epoch_cnt, 1);
    ca_sel = 0; tap_a = 2; tap_b = 6;
    chan_off(1);
    for (int n = 0; n < 2046; n++) step(1, pc ? -100 : 100, 0);
    repeat (4) step(0, 0, 0);
    check("t2_p_i", g24[2], 204600);
    check("t2_p_q", g24[3], 0);
    check("t2_e_q", g24[1], 0);
    dop_freq = 32'h4000_0000;
    chan_off(1);
    for (int n = 0; n < 2046; n++)
      case (n % 4)
        0: step(1, 50, 0);
        1: step(1, 0, 50);
        2: step(1, -50, 0);
        default: step(1, 0, -50);
      endcase
    repeat (4) step(0, 0, 0);
    check("t3_e_i", g24[0], -100);
    check("t3_e_q", g24[1], 0);
    dop_freq = 0;
    code_freq = 32'h0800_0000;
    chan_off(1);
    for (int n = 0; n < 32736; n++) step(1, 127, 0);
    repeat (4) step(0, 0, 0);
    check("t4_l_i12_floor", g12[4] >= -2047, 1);
    check("t4_epoch_cnt", epoch_cnt, 1);
    code_freq = 32'h8000_0000;
    chan_off(1);
    for (int n = 0; n < 2046 + 1400; n++) step(1, 1, 0);
    step(0, 0, 0);
    check("t6_pre_epoch_cnt", epoch_cnt, 1);
    #2 reset = 1;
    #1;
    check("t6_async_epoch_cnt", epoch_cnt, 0);
    check("t6_async_p_i", g24[2], 0);
    check("t6_async_e_i", g24[0], 0);
    check("t6_async_dv_out", dv_out, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 0;
    model_reset();
    for (int n = 0; n < 2046; n++) step(1, 1, 0);
    repeat (4) step(0, 0, 0);
    check("t6_e_i", g24[0], -2);
    check("t6_epoch_cnt", epoch_cnt, 1);
    repeat (4) step(0, 0, 0);
    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/gps_correlator.md
Name: gps_correlator

Overview:
Single-channel GPS L1 C/A receive correlator. It consumes the 8-bit I/Q sample stream produced by gps_emulator (dv_in-qualified) and performs carrier wipeoff with a 4-phase carrier NCO. It despreads against a locally generated C/A code driven by a code NCO, and accumulates early, prompt and late I/Q products over one code period (1023 chips). At each code epoch it dumps the six sums for the tracking loop software.

Parameters:
ACC_W, 24, accumulator/output width (signed, saturating)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
enable  in  1  run; low holds channel in initial state
dv_in  in  1  input sample strobe; may be asserted every cycle
real_in  in  8  signed I sample
imag_in  in  8  signed Q sample
code_freq  in  32  code NCO increment per sample (2^32 = 1 chip/sample)
dop_freq  in  32  carrier NCO increment per sample (2^32 = 1 cycle/sample)
ca_sel  in  6  C/A select, 0-35 = SV1-36; sampled only while enable low
dv_out  out  1  one-clock strobe; dump outputs valid
e_i, e_q, p_i, p_q, l_i, l_q  out  ACC_W each  signed epoch sums
epoch_cnt  out  16  dumps since enable rose, wraps 65535->0

Behaviour:
- Reset, or enable low: code_phase = 0, carr_phase = 0. G1 and G2 are all ones; the G2 taps are latched from ca_sel using the IS-GPS-200 tap pair table. chip_idx = 0; E/P/L chips = first chip; all accumulators = 0. All outputs = 0, dv_out = 0. Reset is valid mid-period: the partial sum is discarded and no dv_out is issued.
- Chip mapping: code bit 0 -> +1, bit 1 -> -1.
- Carrier wipeoff uses carr_phase[31:30] = q:
  - q0 gives (I, Q).
  - q1 gives (Q, -I).
  - q2 gives (-I, -Q).
  - q3 gives (-Q, I).
  - The 9-bit signed result is computed with no overflow.
- Per dv_in (enable high), in this order:
  - The sample is wiped with the current q.
  - It is multiplied by the current E, P and L chips.
  - Then carr_phase += dop_freq and code_phase += code_freq.
- Half-chip event: code_phase[31] changes on the update. On this event: L <= P, then P <= E (old values).
- Full-chip event: the 32-bit add carries out. On this event:
  - G1/G2 shift, and E <= new generator output.
  - chip_idx increments.
  - When chip_idx goes 1022 -> 0, the epoch flag is set.
  - A wrap is both events at once: L <= P, P <= old E, then E updates.
- Pipeline:
  - Stage 1 registers the wiped, despread products.
  - Stage 2 adds them into the accumulators with saturation to ±(2^(ACC_W-1)-1).
- Epoch behaviour:
  - The sample processed on an epoch update is the last sample of the period.
  - Outputs are registered with the final sums, and dv_out pulses exactly 2 clocks after that dv_in.
  - The accumulators restart at the next sample, with no sample lost or double counted.
  - epoch_cnt increments with dv_out.
- Outputs hold between dumps.
- code_freq and dop_freq may change at any time and take effect on the next dv_in.
- Changes to ca_sel while enable is high are ignored.
- enable falling mid-period returns the channel to the initial state and produces no dv_out. The state takes effect in the clock after enable is sampled low.

Test Plan:
1. ca_sel=0, code_freq=32'h8000_0000, dop_freq=0, dv_in every cycle, real_in=+1, imag_in=0 -> first dv_out after 2046 samples + 2 clocks. p_i=-2 (512 ones / 511 zeros), e_i=-2, p_q=0, epoch_cnt=1. The first 10 prompt chips match octal 1440.
2. Input is ±100 × the SV1 chip, aligned to prompt, 2 samples/chip, dop=0 -> p_i=204600 exactly. e_i and l_i equal 100×(1023+R1), where R1 ∈ {-65,-1,63}. All Q sums are 0.
3. dop_freq=32'h4000_0000, input rotating (+50,0), (0,+50), (-50,0), (0,-50)…, chip forced constant via the model -> wiped output is constant (+50,0). Prompt sums are consistent with test 1 scaling ×50.
4. ACC_W=12, real_in=+127 constant, code_freq set so that a full code period exceeds 17 same-sign samples -> sums clamp at ±2047, with no wrap.
5. enable dropped for 3 cycles at chip 500, then raised -> no dv_out for the aborted period. The next dump follows a full 2046-sample period from chip 0, and epoch_cnt restarts at 1.
6. reset pulsed asynchronously mid-clock at chip 700 -> all outputs are 0 immediately. The behaviour after release matches test 1 exactly.
